mod_counter_ud: RTL and testbench
=================================

Name: mod_counter_ud

Overview:
Parametrised up/down modulo counter for the timekeeping and alarm-set datapath. It generalises the minute, second and hour digit counters with:
- programmable MIN/MAX range and a runtime alternate maximum (12 h / 24 h style),
- synchronous load with range clamping,
- carry and borrow pulses for cascading,
- an optional button auto-repeat FSM for fast setting.

One instance per time field; the carry of one stage drives `en` of the next.

Parameters:
- WIDTH, 5, count width; MAX_VAL and ALT_MAX_VAL must both be < 2**WIDTH.
- MIN_VAL, 0, lowest count value; wrap target on increment.
- MAX_VAL, 23, highest count value when alt_mode=0.
- ALT_MAX_VAL, 11, highest count value when alt_mode=1; must satisfy MIN_VAL <= ALT_MAX_VAL <= MAX_VAL.
- RPT_DELAY, 8, rpt_tick pulses a button must be held before auto-repeat starts.
- RPT_RATE, 2, rpt_tick pulses between auto-repeat steps.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- en, in, 1, timebase increment strobe (one step per high cycle).
- count_up, in, 1, single-step increment strobe (debounced button edge).
- count_down, in, 1, single-step decrement strobe.
- load, in, 1, synchronous load strobe.
- load_val, in, WIDTH, value to load.
- alt_mode, in, 1, 1 selects ALT_MAX_VAL as the current max (cur_max).
- up_hold, in, 1, level: increment button held (auto-repeat only).
- down_hold, in, 1, level: decrement button held (auto-repeat only).
- rpt_tick, in, 1, slow auto-repeat timebase strobe.
- count, out, WIDTH, current value.
- carry, out, 1, registered 1-cycle pulse when count wraps cur_max -> MIN_VAL.
- borrow, out, 1, registered 1-cycle pulse when count wraps MIN_VAL -> cur_max.
- at_max, out, 1, combinational: count == cur_max.

Behaviour:
- Reset:
  - All state updates on the rising edge of clk. Reset is synchronous and active-high, and has highest priority.
  - Reset values: count=MIN_VAL, carry=0, borrow=0, repeat FSM=IDLE.
- Per-cycle priority, exactly one action per cycle: reset > load > en > count_down > count_up > auto-repeat step > clamp > hold.
- cur_max = alt_mode ? ALT_MAX_VAL : MAX_VAL.
- Increment (en, count_up, repeat-up):
  - If count >= cur_max: count <= MIN_VAL and carry <= 1.
  - Else count <= count+1.
- Decrement (count_down, repeat-down):
  - If count <= MIN_VAL: count <= cur_max and borrow <= 1.
  - If count > cur_max: count <= cur_max, no borrow.
  - Else count <= count-1.
- Load:
  - count <= clamp(load_val, MIN_VAL, cur_max).
  - Never asserts carry or borrow.
- Clamp: if no other action and count > cur_max (e.g. alt_mode just rose), count <= cur_max next cycle. No pulse.
- carry and borrow default to 0 every cycle they are not set. They never assert together.
- Simultaneous strobes: the lower-priority strobe is dropped, not queued.
  - en with count_up → one step only.
  - en with count_down → en wins.
- Arithmetic is done in WIDTH+1 bits internally, so count+1 never aliases when MAX_VAL = 2**WIDTH-1.
- Latency: count, carry and borrow all reflect an action one clock after the strobe.

Optional Feature:
- Macro: MODCNT_AUTOREPEAT_EN.
- Defined: 3-state repeat FSM.
  - IDLE: if exactly one of up_hold/down_hold is high, latch the direction, clear the tick counter, go to ARMED.
  - ARMED: count rpt_tick pulses. On reaching RPT_DELAY, issue one step in the latched direction and go to REPEAT.
  - REPEAT: issue one step every RPT_RATE rpt_tick pulses.
  - Any state: release of the latched hold, both holds high, or reset → IDLE with the counter cleared.
  - A repeat step is dropped, without retry, if any higher-priority action occurs in that cycle.
- Undefined: no FSM logic; up_hold, down_hold and rpt_tick are ignored. Ports remain for a stable interface.

Test Plan:
1. Reset with count=17, then 24 en pulses (alt_mode=0) → count sequence 0..23 then 0; carry high exactly one cycle, on the 23→0 step.
2. count=0, count_down → count=23 and borrow=1 for one cycle. Repeat with alt_mode=1 → count=11, borrow=1.
3. count=20, alt_mode 0→1 with no strobes → count=11 next cycle, no carry or borrow. Then count_up → 0 with carry=1.
4. load=1 with load_val=30, alt_mode=0 → count=23, no pulse. Same cycle with en=1 → load wins, count=23.
5. count=5, en, count_up and count_down all high together → count=6 (single step, en priority). Reset asserted mid-sequence → count=0 on the next edge.
6. MODCNT_AUTOREPEAT_EN defined, count=0, up_hold held, rpt_tick every 4 clk → first step after the 8th tick, then +1 every 2 ticks. Release up_hold → stepping stops; FSM returns to IDLE.

Source files
------------

// File: rtl/mod_counter_ud.sv
// Up/down modulo counter for one time field (seconds, minutes, hours).
// Range is MIN_VAL..cur_max, where cur_max switches between MAX_VAL and
// ALT_MAX_VAL at runtime. Carry/borrow are registered one-cycle pulses so
// that the carry of one stage can drive the en input of the next stage.
// Optional button auto-repeat: define MODCNT_AUTOREPEAT_EN to build it in.
// Without it, up_hold, down_hold and rpt_tick are accepted but ignored.
module mod_counter_ud #(
  parameter int WIDTH       = 5,
  parameter int MIN_VAL     = 0,
  parameter int MAX_VAL     = 23,
  parameter int ALT_MAX_VAL = 11,
  parameter int RPT_DELAY   = 8,
  parameter int RPT_RATE    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             count_up,
  input  logic             count_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             alt_mode,
  input  logic             up_hold,
  input  logic             down_hold,
  input  logic             rpt_tick,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             borrow,
  output logic             at_max
);

  // One extra bit so that count+1 cannot wrap when MAX_VAL = 2**WIDTH-1
  localparam int W1 = WIDTH + 1;

  logic [W1-1:0]    cnt_x;
  logic [W1-1:0]    max_x;
  logic [W1-1:0]    min_x;
  logic [WIDTH-1:0] count_nx;
  logic             carry_nx;
  logic             borrow_nx;
  logic             rpt_up;
  logic             rpt_down;

  assign cnt_x  = {1'b0, count};
  assign max_x  = alt_mode ? W1'(ALT_MAX_VAL) : W1'(MAX_VAL);
  assign min_x  = W1'(MIN_VAL);
  assign at_max = (cnt_x == max_x);

  // Saturate a value into [lo, hi]
  function automatic logic [WIDTH-1:0] clamp_range(input logic [W1-1:0] v,
                                                   input logic [W1-1:0] lo,
                                                   input logic [W1-1:0] hi);
    logic [W1-1:0] r;
    if (v < lo)      r = lo;
    else if (v > hi) r = hi;
    else             r = v;
    return r[WIDTH-1:0];
  endfunction

`ifdef MODCNT_AUTOREPEAT_EN
  typedef enum logic [1:0] {IDLE, ARMED, REPEAT} rpt_state_t;

  localparam int TMAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
  localparam int TW   = $clog2(TMAX + 1);

  rpt_state_t    state;
  rpt_state_t    state_nx;
  logic [TW-1:0] tick_cnt;
  logic [TW-1:0] tick_nx;
  logic          dir_up;
  logic          dir_nx;
  logic          hold_ok;

  // Latched button still held alone; anything else aborts the repeat
  assign hold_ok = (dir_up ? up_hold : down_hold) && !(up_hold && down_hold);

  // Repeat FSM state, tick counter and latched direction
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      dir_up   <= 1'b0;
    end else begin
      state    <= state_nx;
      tick_cnt <= tick_nx;
      dir_up   <= dir_nx;
    end
  end

  // Repeat FSM next-state: arm on a single held button, count rpt_tick pulses
  always_comb begin
    state_nx = state;
    tick_nx  = tick_cnt;
    dir_nx   = dir_up;
    case (state)
      IDLE: begin
        if (up_hold ^ down_hold) begin
          dir_nx   = up_hold;
          tick_nx  = '0;
          state_nx = ARMED;
        end
      end
      ARMED: begin
        if (!hold_ok) begin
          state_nx = IDLE;
          tick_nx  = '0;
        end else if (rpt_tick) begin
          if (tick_cnt == TW'(RPT_DELAY - 1)) begin
            state_nx = REPEAT;
            tick_nx  = '0;
          end else begin
            tick_nx = tick_cnt + TW'(1);
          end
        end
      end
      REPEAT: begin
        if (!hold_ok) begin
          state_nx = IDLE;
          tick_nx  = '0;
        end else if (rpt_tick) begin
          if (tick_cnt == TW'(RPT_RATE - 1)) tick_nx = '0;
          else                               tick_nx = tick_cnt + TW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        tick_nx  = '0;
      end
    endcase
  end

  // Repeat FSM outputs: one step request on the tick that completes a period
  always_comb begin
    rpt_up   = 1'b0;
    rpt_down = 1'b0;
    if (hold_ok && rpt_tick) begin
      if ((state == ARMED  && tick_cnt == TW'(RPT_DELAY - 1)) ||
          (state == REPEAT && tick_cnt == TW'(RPT_RATE - 1))) begin
        rpt_up   = dir_up;
        rpt_down = !dir_up;
      end
    end
  end
`else
  logic unused_rpt;

  assign unused_rpt = ^{up_hold, down_hold, rpt_tick};
  assign rpt_up     = 1'b0;
  assign rpt_down   = 1'b0;
`endif

  // Next count and pulses: exactly one action per cycle, highest priority first
  always_comb begin
    count_nx  = count;
    carry_nx  = 1'b0;
    borrow_nx = 1'b0;
    if (load) begin
      count_nx = clamp_range({1'b0, load_val}, min_x, max_x);
    end else if (en || (!count_down && count_up) ||
                 (!count_down && !count_up && rpt_up)) begin
      if (cnt_x >= max_x) begin
        count_nx = min_x[WIDTH-1:0];
        carry_nx = 1'b1;
      end else begin
        count_nx = WIDTH'(cnt_x + W1'(1));
      end
    end else if (count_down || rpt_down) begin
      if (cnt_x <= min_x) begin
        count_nx  = max_x[WIDTH-1:0];
        borrow_nx = 1'b1;
      end else if (cnt_x > max_x) begin
        count_nx = max_x[WIDTH-1:0];
      end else begin
        count_nx = WIDTH'(cnt_x - W1'(1));
      end
    end else if (cnt_x > max_x) begin
      count_nx = max_x[WIDTH-1:0];
    end
  end

  // Count and pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= WIDTH'(MIN_VAL);
      carry  <= 1'b0;
      borrow <= 1'b0;
    end else begin
      count  <= count_nx;
      carry  <= carry_nx;
      borrow <= borrow_nx;
    end
  end

endmodule

// File: tb/tb_mod_counter_ud.sv
// Scoreboard bench for mod_counter_ud (default parameters 0..23 / 0..11).
// The driver pushes the hand-computed post-edge state for every cycle it
// drives; the monitor pops and compares one entry after each rising edge.
module tb_mod_counter_ud;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       count_up = 1'b0;
  logic       count_down = 1'b0;
  logic       load = 1'b0;
  logic [4:0] load_val = '0;
  logic       alt_mode = 1'b0;
  logic       up_hold = 1'b0;
  logic       down_hold = 1'b0;
  logic       rpt_tick = 1'b0;
  logic [4:0] count;
  logic       carry;
  logic       borrow;
  logic       at_max;

  typedef struct {
    logic [4:0] c;
    logic       cy;
    logic       br;
    logic       am;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  mod_counter_ud dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .count_up   (count_up),
    .count_down (count_down),
    .load       (load),
    .load_val   (load_val),
    .alt_mode   (alt_mode),
    .up_hold    (up_hold),
    .down_hold  (down_hold),
    .rpt_tick   (rpt_tick),
    .count      (count),
    .carry      (carry),
    .borrow     (borrow),
    .at_max     (at_max)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus and record the expected state after the edge
  task automatic cycx(input logic r, input logic e, input logic u, input logic d,
                      input logic l, input logic [4:0] lv, input logic a,
                      input logic uh, input logic dh, input logic tk,
                      input logic [4:0] ec, input logic ecy, input logic ebr,
                      input string nm);
    exp_t x;
    @(negedge clk);
    reset = r; en = e; count_up = u; count_down = d;
    load = l; load_val = lv; alt_mode = a;
    up_hold = uh; down_hold = dh; rpt_tick = tk;
    x.c = ec; x.cy = ecy; x.br = ebr;
    x.am = (ec == (a ? 5'd11 : 5'd23));
    x.nm = nm;
    q.push_back(x);
  endtask

  task automatic cyc(input logic r, input logic e, input logic u, input logic d,
                     input logic l, input logic [4:0] lv, input logic a,
                     input logic [4:0] ec, input logic ecy, input logic ebr,
                     input string nm);
    cycx(r, e, u, d, l, lv, a, 1'b0, 1'b0, 1'b0, ec, ecy, ebr, nm);
  endtask

  // Monitor: compare one expectation per rising edge, away from the edge
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        checks++;
        if ({count, carry, borrow, at_max} !== {x.c, x.cy, x.br, x.am}) begin
          errors++;
          $display("FAIL %s: got count=%0d carry=%0b borrow=%0b at_max=%0b, expected count=%0d carry=%0b borrow=%0b at_max=%0b",
                   x.nm, count, carry, borrow, at_max, x.c, x.cy, x.br, x.am);
        end
      end
    end
  end

  // Driver: directed vectors
  initial begin
    int exp_c;
    int ticks;
    // Reset, load 17, reset again
    cyc(1, 0, 0, 0, 0, 0,  0, 0,  0, 0, "reset");
    cyc(0, 0, 0, 0, 1, 17, 0, 17, 0, 0, "load17");
    cyc(1, 0, 0, 0, 0, 0,  0, 0,  0, 0, "reset_from17");
    // 24 timebase pulses: 1..23 then wrap to 0 with carry
    for (int i = 1; i <= 23; i++) cyc(0, 1, 0, 0, 0, 0, 0, 5'(i), 0, 0, "en_step");
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, "en_wrap_carry");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "carry_drops");
    // Decrement wrap in both modes
    cyc(0, 0, 0, 1, 0, 0, 0, 23, 0, 1, "down_wrap24");
    cyc(0, 0, 0, 0, 0, 0, 0, 23, 0, 0, "borrow_drops");
    cyc(0, 0, 0, 0, 1, 0, 0, 0,  0, 0, "load0");
    cyc(0, 0, 0, 1, 0, 0, 1, 11, 0, 1, "down_wrap12");
    cyc(0, 0, 0, 0, 0, 0, 1, 11, 0, 0, "hold12");
    // Clamp when alt_mode rises, then increment from cur_max
    cyc(0, 0, 0, 0, 1, 20, 0, 20, 0, 0, "load20");
    cyc(0, 0, 0, 0, 0, 0,  1, 11, 0, 0, "alt_clamp");
    cyc(0, 0, 1, 0, 0, 0,  1, 0,  1, 0, "up_wrap12");
    // Decrement while above cur_max: clamp, no borrow
    cyc(0, 0, 0, 0, 1, 20, 0, 20, 0, 0, "load20b");
    cyc(0, 0, 0, 1, 0, 0,  1, 11, 0, 0, "down_above_max");
    // Load clamping and priority over en
    cyc(0, 0, 0, 0, 1, 30, 0, 23, 0, 0, "load30_clamp");
    cyc(0, 1, 0, 0, 1, 30, 0, 23, 0, 0, "load_beats_en");
    cyc(0, 0, 0, 0, 1, 15, 1, 11, 0, 0, "load15_alt");
    // Simultaneous strobes
    cyc(0, 0, 0, 0, 1, 5, 0, 5, 0, 0, "load5");
    cyc(0, 1, 1, 1, 0, 0, 0, 6, 0, 0, "en_up_down");
    cyc(0, 1, 0, 1, 0, 0, 0, 7, 0, 0, "en_beats_down");
    cyc(0, 0, 1, 0, 0, 0, 0, 8, 0, 0, "up_only");
    cyc(0, 0, 0, 1, 0, 0, 0, 7, 0, 0, "down_only");
    cyc(0, 0, 1, 1, 0, 0, 0, 6, 0, 0, "down_beats_up");
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, "reset_mid");
`ifdef MODCNT_AUTOREPEAT_EN
    // Hold up: first step on tick 8, then one step every 2 ticks
    exp_c = 0;
    ticks = 0;
    for (int i = 0; i < 48; i++) begin
      if (i % 4 == 3) begin
        ticks++;
        if (ticks == 8 || (ticks > 8 && (ticks - 8) % 2 == 0)) exp_c++;
      end
      cycx(0, 0, 0, 0, 0, 0, 0, 1, 0, (i % 4 == 3), 5'(exp_c), 0, 0, "rpt_up");
    end
    // Release: stepping stops even though ticks continue
    for (int i = 0; i < 16; i++)
      cycx(0, 0, 0, 0, 0, 0, 0, 0, 0, (i % 4 == 3), 5'(exp_c), 0, 0, "rpt_release");
`else
    // Hold inputs are ignored in the default build
    exp_c = 0;
    ticks = 0;
    for (int i = 0; i < 48; i++) begin
      if (i % 4 == 3) ticks++;
      cycx(0, 0, 0, 0, 0, 0, 0, 1, 0, (i % 4 == 3), 5'(exp_c), 0, 0, "hold_ignored");
    end
`endif
    cyc(0, 0, 0, 0, 0, 0, 0, 5'(exp_c), 0, 0, "final_idle");
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    if (!done) begin
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
    end
  end

endmodule
